// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants, pixel/word geometry and the RAM grant encoding
// shared by the frame-buffer arbiter and its prefetch FIFO.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END = 752;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END = 492;
  localparam int PIX_W = 3;
  localparam int WORD_PIX = 4;
  localparam int WORD_W = PIX_W * WORD_PIX;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE / WORD_PIX;
  typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_HOST} gnt_e;
endpackage

// File: rtl/vga_pix_fifo.sv
// vga_pix_fifo: synchronous show-ahead word FIFO with flush and level output;
// pops on an empty FIFO are ignored.
module vga_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 12
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign head_o = mem_q[rd_q];
  assign level_o = cnt_q;
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  // The arbiter's inflight accounting must never let a fetch land on a full FIFO.
  assert property (@(posedge clk) disable iff (!reset_n) !(push_i && cnt_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port frame-buffer RAM between prefetched VGA scanout
// and a host req/ack port. Define VGA_ARB_STATS_EN to add the saturating underflow_count output.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WM = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [11:0]       host_wdata,
  output logic              host_ack,
  output logic [11:0]       host_rdata,
  output logic [2:0]        pix_rgb,
  output logic              underflow
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0]       underflow_count
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  gnt_e gnt_d, gnt_q;
  logic [ADDR_W-1:0] fetch_q;
  logic pf_en_q, underflow_q;
  logic [PIX_W-1:0] pix_q;
  logic [WORD_W-1:0] rdata_q, head;
  logic [LW-1:0] level;
  logic [LW:0] occ;
  logic [3:0] sel;
  logic empty, restart, video_on, host_elig, disp_ok, starve, pop, push;
  assign restart = pixel_y == 10'(V_TOTAL - 1) && pixel_x == 10'd0;
  assign video_on = pixel_x < 10'(H_ACTIVE) && pixel_y < 10'(V_ACTIVE);
  assign occ = {1'b0, level} + (LW+1)'(gnt_q == GNT_DISP);
  assign host_elig = reset_n && host_req && !host_ack;
  // No fetch in the restart cycle: the fetch address is being cleared underneath it.
  assign disp_ok = pf_en_q && !restart && fetch_q < ADDR_W'(FB_WORDS) && occ < (LW+1)'(FIFO_DEPTH);
  assign starve = video_on && empty;
  assign pop = video_on && pixel_x[1:0] == 2'd3;
  assign push = gnt_q == GNT_DISP && !restart;
  assign sel = 4'(pixel_x[1:0]) * 4'd3;
  assign pix_rgb = pix_q;
  assign underflow = underflow_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) gnt_q <= GNT_IDLE;
    else gnt_q <= gnt_d;
  always_comb
    gnt_d = disp_ok && (occ < (LW+1)'(LOW_WM) || !host_elig) ? GNT_DISP :
            host_elig ? GNT_HOST : GNT_IDLE;
  always_comb begin
    mem_addr = gnt_d == GNT_HOST ? host_addr : fetch_q;
    mem_we = gnt_d == GNT_HOST && host_we;
    mem_wdata = host_wdata;
    host_ack = gnt_q == GNT_HOST;
    host_rdata = host_ack && !host_we ? mem_rdata : rdata_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pf_en_q <= 1'b0;
      fetch_q <= '0;
      rdata_q <= '0;
      pix_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      pf_en_q <= pf_en_q | restart;
      fetch_q <= restart ? '0 : fetch_q + ADDR_W'(gnt_d == GNT_DISP);
      rdata_q <= host_rdata;
      pix_q <= video_on && !empty ? head[sel +: PIX_W] : '0;
      underflow_q <= underflow_q | starve;
    end
  vga_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .flush_i(restart),
    .push_i(push),
    .data_i(mem_rdata),
    .pop_i(pop),
    .head_o(head),
    .level_o(level),
    .empty_o(empty)
  );
`ifdef VGA_ARB_STATS_EN
  logic [15:0] ucnt_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ucnt_q <= '0;
    else if (starve && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  assign underflow_count = ucnt_q;
`endif
endmodule
